// File: rtl/avalon_write_master_if.sv
// Avalon-MM write bus between the write-master engine and an SDRAM slave.
//   master_address     byte address of the current write
//   master_write       write request
//   master_byteenable  byte lanes (always all ones from this master)
//   master_writedata   write data
//   master_waitrequest slave stall; request fields are held while high
interface avalon_write_master_if #(
  parameter int unsigned ADDRESSWIDTH    = 28,
  parameter int unsigned DATAWIDTH       = 32,
  parameter int unsigned BYTEENABLEWIDTH = 4
);
  logic [ADDRESSWIDTH-1:0]    master_address;
  logic                       master_write;
  logic [BYTEENABLEWIDTH-1:0] master_byteenable;
  logic [DATAWIDTH-1:0]       master_writedata;
  logic                       master_waitrequest;

  modport master (
    output master_address,
    output master_write,
    output master_byteenable,
    output master_writedata,
    input  master_waitrequest
  );

  modport slave (
    input  master_address,
    input  master_write,
    input  master_byteenable,
    input  master_writedata,
    output master_waitrequest
  );
endinterface

// File: rtl/avalon_write_master.sv
// Write-master engine: buffers user words in a small FIFO and drains them
// as single-beat Avalon-MM writes starting at a programmed base address.
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-low reset
//   control_fixed_location  keep the address constant for the whole transfer
//   control_write_base      start byte address
//   control_write_length    transfer length in bytes (word multiple)
//   control_go              one-cycle start pulse, honoured only while idle
//   control_done            high while idle
//   user_write_buffer       push user_buffer_data into the FIFO
//   user_buffer_data        word to push
//   user_buffer_full        FIFO holds FIFODEPTH words; pushes are dropped
//   avm                     Avalon-MM write master bus
module avalon_write_master #(
  parameter int unsigned ADDRESSWIDTH    = 28,
  parameter int unsigned DATAWIDTH       = 32,
  parameter int unsigned BYTEENABLEWIDTH = 4,
  parameter int unsigned FIFODEPTH       = 8,
  parameter int unsigned FIFODEPTH_LOG2  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    control_fixed_location,
  input  logic [ADDRESSWIDTH-1:0] control_write_base,
  input  logic [ADDRESSWIDTH-1:0] control_write_length,
  input  logic                    control_go,
  output logic                    control_done,
  input  logic                    user_write_buffer,
  input  logic [DATAWIDTH-1:0]    user_buffer_data,
  output logic                    user_buffer_full,
  avalon_write_master_if.master   avm
);

  localparam int unsigned BE_LOG2 = (BYTEENABLEWIDTH > 1) ? $clog2(BYTEENABLEWIDTH) : 0;
  localparam int unsigned CNT_W   = FIFODEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_ZERO  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [ADDRESSWIDTH-1:0] remaining_q, remaining_d;
  logic                    fixed_q, fixed_d;

  logic [DATAWIDTH-1:0]      mem_q [FIFODEPTH];
  logic [DATAWIDTH-1:0]      mem_d [FIFODEPTH];
  logic [FIFODEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFODEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;

  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    write_en;
  logic [ADDRESSWIDTH-1:0] len_words;

  // Low length bits below one word are discarded by the shift.
  assign len_words = control_write_length >> BE_LOG2;

  assign fifo_empty       = (count_q == '0);
  assign user_buffer_full = (count_q == CNT_W'(FIFODEPTH));
  assign push             = user_write_buffer && !user_buffer_full;
  assign pop              = write_en && !avm.master_waitrequest;

  // ---------------------------------------------------------------- FIFO
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = user_buffer_data;
      wr_ptr_d        = wr_ptr_q + FIFODEPTH_LOG2'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + FIFODEPTH_LOG2'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset: its contents are only observable through the
  // head while the count says the entry is valid, and writedata is gated.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ------------------------------------------------------ control FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      fixed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      fixed_q     <= fixed_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    fixed_d      = fixed_q;
    control_done = 1'b0;
    write_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        control_done = 1'b1;
        if (control_go) begin
          addr_d      = control_write_base;
          remaining_d = len_words;
          fixed_d     = control_fixed_location;
          state_d     = (len_words == '0) ? S_ZERO : S_WRITE;
        end
      end
      S_ZERO: begin
        state_d = S_IDLE;
      end
      S_WRITE: begin
        // Request whenever a word is queued; with an empty FIFO the engine
        // simply waits here for more data.
        write_en = !fifo_empty;
        if (write_en && !avm.master_waitrequest) begin
          remaining_d = remaining_q - ADDRESSWIDTH'(1);
          if (!fixed_q) begin
            addr_d = addr_q + ADDRESSWIDTH'(BYTEENABLEWIDTH);
          end
          if (remaining_q == ADDRESSWIDTH'(1)) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Address and head data only change on an accepted beat, so both stay
  // stable while the slave stalls.
  assign avm.master_write      = write_en;
  assign avm.master_address    = addr_q;
  assign avm.master_byteenable = '1;
  assign avm.master_writedata  = write_en ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_avalon_write_master.sv
module tb_avalon_write_master;
  localparam int unsigned AW    = 28;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = 4;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          control_fixed_location;
  logic [AW-1:0] control_write_base;
  logic [AW-1:0] control_write_length;
  logic          control_go;
  logic          control_done;
  logic          user_write_buffer;
  logic [DW-1:0] user_buffer_data;
  logic          user_buffer_full;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mq[$];

  avalon_write_master_if #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .BYTEENABLEWIDTH(BW)) bus ();

  avalon_write_master #(
    .ADDRESSWIDTH(AW), .DATAWIDTH(DW), .BYTEENABLEWIDTH(BW),
    .FIFODEPTH(DEPTH), .FIFODEPTH_LOG2(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .control_fixed_location(control_fixed_location),
    .control_write_base(control_write_base),
    .control_write_length(control_write_length),
    .control_go(control_go),
    .control_done(control_done),
    .user_write_buffer(user_write_buffer),
    .user_buffer_data(user_buffer_data),
    .user_buffer_full(user_buffer_full),
    .avm(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs set afterwards are seen at the next edge and
  // outputs read afterwards reflect the state just clocked in.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    user_write_buffer = 1'b1;
    user_buffer_data  = d;
    tick();
    user_write_buffer = 1'b0;
  endtask

  task automatic start(input logic [AW-1:0] base, input logic [AW-1:0] len, input logic fixed);
    control_write_base     = base;
    control_write_length   = len;
    control_fixed_location = fixed;
    control_go             = 1'b1;
    tick();
    control_go = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    tick();
    tick();
    n_cmp++; if (control_done !== 1'b1) begin n_err++; $display("FAIL reset_done: got %b want 1", control_done); end
    n_cmp++; if (user_buffer_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", user_buffer_full); end
    n_cmp++; if (bus.master_write !== 1'b0) begin n_err++; $display("FAIL reset_write: got %b want 0", bus.master_write); end
    n_cmp++; if (bus.master_address !== 28'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", bus.master_address); end
    n_cmp++; if (bus.master_writedata !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", bus.master_writedata); end
    n_cmp++; if (bus.master_byteenable !== 4'hF) begin n_err++; $display("FAIL reset_be: got %h want f", bus.master_byteenable); end
    reset = 1'b1;
    tick();
    n_cmp++; if (control_done !== 1'b1) begin n_err++; $display("FAIL post_reset_done: got %b want 1", control_done); end
  endtask

  task automatic test_single_word();
    control_write_base     = 28'h8000090;
    control_write_length   = 28'd4;
    control_fixed_location = 1'b0;
    control_go             = 1'b1;
    user_write_buffer      = 1'b1;
    user_buffer_data       = 32'hDEADBEEF;
    tick();
    control_go        = 1'b0;
    user_write_buffer = 1'b0;
    n_cmp++; if (bus.master_write !== 1'b1) begin n_err++; $display("FAIL single_write: got %b want 1", bus.master_write); end
    n_cmp++; if (bus.master_address !== 28'h8000090) begin n_err++; $display("FAIL single_addr: got %h want 8000090", bus.master_address); end
    n_cmp++; if (bus.master_writedata !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data: got %h want deadbeef", bus.master_writedata); end
    n_cmp++; if (bus.master_byteenable !== 4'hF) begin n_err++; $display("FAIL single_be: got %h want f", bus.master_byteenable); end
    n_cmp++; if (control_done !== 1'b0) begin n_err++; $display("FAIL single_busy: got %b want 0", control_done); end
    tick();
    n_cmp++; if (control_done !== 1'b1) begin n_err++; $display("FAIL single_done: got %b want 1", control_done); end
    n_cmp++; if (bus.master_write !== 1'b0) begin n_err++; $display("FAIL single_idle_write: got %b want 0", bus.master_write); end
  endtask

  task automatic test_burst();
    logic [DW-1:0] words [4];
    logic [AW-1:0] base;
    logic [AW-1:0] exp_a;
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
    base = 28'h8000000;
    for (int i = 0; i < 4; i++) push_word(words[i]);
    start(base, 28'd16, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_a = base + AW'(i * BW);
      n_cmp++; if (bus.master_write !== 1'b1) begin n_err++; $display("FAIL burst_write[%0d]: got %b want 1", i, bus.master_write); end
      n_cmp++; if (bus.master_address !== exp_a) begin n_err++; $display("FAIL burst_addr[%0d]: got %h want %h", i, bus.master_address, exp_a); end
      n_cmp++; if (bus.master_writedata !== words[i]) begin n_err++; $display("FAIL burst_data[%0d]: got %h want %h", i, bus.master_writedata, words[i]); end
      n_cmp++; if (control_done !== 1'b0) begin n_err++; $display("FAIL burst_busy[%0d]: got %b want 0", i, control_done); end
      tick();
    end
    n_cmp++; if (control_done !== 1'b1) begin n_err++; $display("FAIL burst_done: got %b want 1", control_done); end
    n_cmp++; if (bus.master_write !== 1'b0) begin n_err++; $display("FAIL burst_end_write: got %b want 0", bus.master_write); end
  endtask

  task automatic test_fixed_location();
    logic [DW-1:0] w;
    for (int i = 0; i < 3; i++) push_word(32'hF1000 + DW'(i));
    start(28'h8000068, 28'd12, 1'b1);
    for (int i = 0; i < 3; i++) begin
      w = 32'hF1000 + DW'(i);
      n_cmp++; if (bus.master_write !== 1'b1) begin n_err++; $display("FAIL fixed_write[%0d]: got %b want 1", i, bus.master_write); end
      n_cmp++; if (bus.master_address !== 28'h8000068) begin n_err++; $display("FAIL fixed_addr[%0d]: got %h want 8000068", i, bus.master_address); end
      n_cmp++; if (bus.master_writedata !== w) begin n_err++; $display("FAIL fixed_data[%0d]: got %h want %h", i, bus.master_writedata, w); end
      tick();
    end
    n_cmp++; if (control_done !== 1'b1) begin n_err++; $display("FAIL fixed_done: got %b want 1", control_done); end
    n_cmp++; if (bus.master_address !== 28'h8000068) begin n_err++; $display("FAIL fixed_final_addr: got %h want 8000068", bus.master_address); end
    control_fixed_location = 1'b0;
  endtask

  task automatic test_waitrequest_stall();
    int accepts = 0;
    push_word(32'hA5A50001);
    bus.master_waitrequest = 1'b1;
    start(28'h8000100, 28'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.master_waitrequest = 1'b0;
      n_cmp++; if (bus.master_write !== 1'b1) begin n_err++; $display("FAIL stall_write[%0d]: got %b want 1", i, bus.master_write); end
      n_cmp++; if (bus.master_address !== 28'h8000100) begin n_err++; $display("FAIL stall_addr[%0d]: got %h want 8000100", i, bus.master_address); end
      n_cmp++; if (bus.master_writedata !== 32'hA5A50001) begin n_err++; $display("FAIL stall_data[%0d]: got %h want a5a50001", i, bus.master_writedata); end
      if (bus.master_write === 1'b1 && bus.master_waitrequest === 1'b0) accepts++;
      tick();
    end
    n_cmp++; if (accepts !== 1) begin n_err++; $display("FAIL stall_accepts: got %0d want 1", accepts); end
    n_cmp++; if (control_done !== 1'b1) begin n_err++; $display("FAIL stall_done: got %b want 1", control_done); end
    // FIFO must be empty now: a new transfer waits with no request.
    start(28'h8000200, 28'd4, 1'b0);
    n_cmp++; if (bus.master_write !== 1'b0) begin n_err++; $display("FAIL stall_empty_write: got %b want 0", bus.master_write); end
    n_cmp++; if (control_done !== 1'b0) begin n_err++; $display("FAIL stall_empty_busy: got %b want 0", control_done); end
    tick();
    n_cmp++; if (control_done !== 1'b0) begin n_err++; $display("FAIL stall_wait_busy: got %b want 0", control_done); end
    push_word(32'h77);
    n_cmp++; if (bus.master_writedata !== 32'h77 || bus.master_write !== 1'b1) begin n_err++; $display("FAIL stall_late_data: got %b/%h want 1/77", bus.master_write, bus.master_writedata); end
    tick();
    n_cmp++; if (control_done !== 1'b1) begin n_err++; $display("FAIL stall_late_done: got %b want 1", control_done); end
  endtask

  task automatic test_full_overflow();
    logic [AW-1:0] exp_a;
    for (int i = 1; i <= 9; i++) begin
      push_word(DW'(i));
      n_cmp++; if (user_buffer_full !== (i >= 8)) begin n_err++; $display("FAIL full_after_push[%0d]: got %b want %b", i, user_buffer_full, (i >= 8)); end
    end
    start(28'h8000300, 28'd32, 1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_a = 28'h8000300 + AW'(i * BW);
      n_cmp++; if (bus.master_write !== 1'b1 || bus.master_writedata !== DW'(i + 1)) begin n_err++; $display("FAIL full_data[%0d]: got %b/%h want 1/%h", i, bus.master_write, bus.master_writedata, DW'(i + 1)); end
      n_cmp++; if (bus.master_address !== exp_a) begin n_err++; $display("FAIL full_addr[%0d]: got %h want %h", i, bus.master_address, exp_a); end
      tick();
    end
    n_cmp++; if (control_done !== 1'b1 || bus.master_write !== 1'b0) begin n_err++; $display("FAIL full_done: got %b/%b want 1/0", control_done, bus.master_write); end
    n_cmp++; if (user_buffer_full !== 1'b0) begin n_err++; $display("FAIL full_drained: got %b want 0", user_buffer_full); end
  endtask

  task automatic test_zero_length();
    // Length 3 is below one word, so it counts as zero words.
    start(28'h8000400, 28'd3, 1'b0);
    n_cmp++; if (control_done !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %b want 0", control_done); end
    n_cmp++; if (bus.master_write !== 1'b0) begin n_err++; $display("FAIL zero_write: got %b want 0", bus.master_write); end
    // A go during the zero cycle is not idle and must be ignored.
    start(28'h8000500, 28'd4, 1'b0);
    n_cmp++; if (control_done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b want 1", control_done); end
    tick();
    n_cmp++; if (control_done !== 1'b1) begin n_err++; $display("FAIL zero_go_ignored: got %b want 1", control_done); end
  endtask

  task automatic test_reset_mid_transfer();
    for (int i = 0; i < 4; i++) push_word(32'hB000 + DW'(i));
    start(28'h8000600, 28'd16, 1'b0);
    tick();
    n_cmp++; if (bus.master_address !== 28'h8000604) begin n_err++; $display("FAIL mid_addr: got %h want 8000604", bus.master_address); end
    reset = 1'b0;
    #1;
    n_cmp++; if (control_done !== 1'b1 || bus.master_write !== 1'b0) begin n_err++; $display("FAIL mid_reset_ctrl: got %b/%b want 1/0", control_done, bus.master_write); end
    n_cmp++; if (bus.master_address !== 28'h0 || bus.master_writedata !== 32'h0) begin n_err++; $display("FAIL mid_reset_bus: got %h/%h want 0/0", bus.master_address, bus.master_writedata); end
    n_cmp++; if (user_buffer_full !== 1'b0 || bus.master_byteenable !== 4'hF) begin n_err++; $display("FAIL mid_reset_misc: got %b/%h want 0/f", user_buffer_full, bus.master_byteenable); end
    tick();
    reset = 1'b1;
    tick();
    push_word(32'hCAFE0001);
    start(28'h8000700, 28'd4, 1'b0);
    n_cmp++; if (bus.master_write !== 1'b1 || bus.master_writedata !== 32'hCAFE0001) begin n_err++; $display("FAIL after_reset_data: got %b/%h want 1/cafe0001", bus.master_write, bus.master_writedata); end
    n_cmp++; if (bus.master_address !== 28'h8000700) begin n_err++; $display("FAIL after_reset_addr: got %h want 8000700", bus.master_address); end
    tick();
    n_cmp++; if (control_done !== 1'b1) begin n_err++; $display("FAIL after_reset_done: got %b want 1", control_done); end
  endtask

  // Reference: a queue holds accepted user words; a transfer of k words
  // writes queue entries in order to base + i*BW (or base when fixed).
  task automatic test_random();
    logic          busy = 1'b0;
    logic          zero_cyc = 1'b0;
    logic          m_fixed = 1'b0;
    logic [AW-1:0] m_base = '0;
    int            m_k = 0;
    int            m_idx = 0;
    logic          exp_done, exp_write, wait_r, push_r, go_r, accepted;
    logic [AW-1:0] exp_a, len_r, base_r;
    logic          fixed_r;
    int            words;
    mq.delete();
    for (int c = 0; c < 3000; c++) begin
      exp_done  = !busy && !zero_cyc;
      exp_write = busy && (mq.size() > 0);
      n_cmp++; if (control_done !== exp_done) begin n_err++; $display("FAIL rnd_done@%0d: got %b want %b", c, control_done, exp_done); end
      n_cmp++; if (bus.master_write !== exp_write) begin n_err++; $display("FAIL rnd_write@%0d: got %b want %b", c, bus.master_write, exp_write); end
      n_cmp++; if (user_buffer_full !== (mq.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full@%0d: got %b want %b", c, user_buffer_full, (mq.size() == DEPTH)); end
      if (exp_write) begin
        exp_a = m_fixed ? m_base : m_base + AW'(m_idx * BW);
        n_cmp++; if (bus.master_address !== exp_a) begin n_err++; $display("FAIL rnd_addr@%0d: got %h want %h", c, bus.master_address, exp_a); end
        n_cmp++; if (bus.master_writedata !== mq[0]) begin n_err++; $display("FAIL rnd_data@%0d: got %h want %h", c, bus.master_writedata, mq[0]); end
      end
      wait_r  = ($urandom_range(0, 3) == 0);
      push_r  = ($urandom_range(0, 2) != 0);
      go_r    = ($urandom_range(0, 5) == 0);
      words   = $urandom_range(0, 6);
      base_r  = AW'($urandom);
      fixed_r = $urandom_range(0, 3) == 0;
      len_r   = AW'(words * BW + $urandom_range(0, BW - 1));
      bus.master_waitrequest = wait_r;
      user_write_buffer      = push_r;
      user_buffer_data       = $urandom;
      control_go             = go_r;
      control_write_base     = base_r;
      control_write_length   = len_r;
      control_fixed_location = fixed_r;
      accepted = exp_write && !wait_r;
      if (accepted) begin
        void'(mq.pop_front());
        m_idx++;
        if (m_idx == m_k) busy = 1'b0;
      end
      if (push_r && (mq.size() + (accepted ? 1 : 0)) < DEPTH) mq.push_back(user_buffer_data);
      zero_cyc = 1'b0;
      if (exp_done && go_r) begin
        if (words == 0) zero_cyc = 1'b1;
        else begin
          busy = 1'b1; m_k = words; m_idx = 0; m_base = base_r; m_fixed = fixed_r;
        end
      end
      tick();
    end
    control_go             = 1'b0;
    user_write_buffer      = 1'b0;
    bus.master_waitrequest = 1'b0;
  endtask

  initial begin
    control_fixed_location = 1'b0;
    control_write_base     = '0;
    control_write_length   = '0;
    control_go             = 1'b0;
    user_write_buffer      = 1'b0;
    user_buffer_data       = '0;
    bus.master_waitrequest = 1'b0;
    test_reset();
    test_single_word();
    test_burst();
    test_fixed_location();
    test_waitrequest_stall();
    test_full_overflow();
    test_zero_length();
    test_reset_mid_transfer();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/avalon_write_master.md
Name: avalon_write_master

Overview:
- Write-master engine behind the user-logic control/user-buffer write interface (go/base/length/done, write_buffer/data/full).
- Accepts write requests and buffers user data in an internal FIFO.
- Issues single-beat Avalon-MM writes toward SDRAM, honouring waitrequest.
- Signals completion with a level done flag that the user logic polls before starting the next request.

Parameters:
- ADDRESSWIDTH, 28, byte address width of base, length and master_address
- DATAWIDTH, 32, data word width
- BYTEENABLEWIDTH, 4, bytes per word; address/length step
- FIFODEPTH, 8, user-buffer depth in words, power of two
- FIFODEPTH_LOG2, 3, log2(FIFODEPTH)

Ports:
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-low reset
- control_fixed_location  in  1  1 = do not increment address during the transfer
- control_write_base  in  ADDRESSWIDTH  start byte address
- control_write_length  in  ADDRESSWIDTH  bytes to transfer, multiple of BYTEENABLEWIDTH
- control_go  in  1  one-cycle start pulse
- control_done  out  1  high while idle; low from the cycle after an accepted go until the last word is accepted
- user_write_buffer  in  1  push user_buffer_data into the FIFO
- user_buffer_data  in  DATAWIDTH  data to push
- user_buffer_full  out  1  FIFO holds FIFODEPTH words
- master_address  out  ADDRESSWIDTH  Avalon byte address
- master_write  out  1  Avalon write request
- master_byteenable  out  BYTEENABLEWIDTH  constant all ones
- master_writedata  out  DATAWIDTH  Avalon write data
- master_waitrequest  in  1  slave stall

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, FIFO emptied, address and remaining registers = 0.
  - Output values during and after reset: control_done=1, user_buffer_full=0, master_write=0, master_address=0, master_writedata=0, master_byteenable=all ones.
- FIFO:
  - Push accepted iff user_write_buffer && !user_buffer_full; a push while full is dropped silently.
  - Pop iff master_write && !master_waitrequest.
  - Push and pop in the same cycle leave the count unchanged.
  - user_buffer_full = (count == FIFODEPTH), derived from the registered count.
  - A push is visible to the master side the next cycle.
  - Words left after a transfer stay queued for the next request.
- State IDLE:
  - control_done=1, master_write=0.
  - On control_go: latch base into the address register, length[ADDRESSWIDTH-1:log2(BYTEENABLEWIDTH)] words into the remaining register (low length bits ignored), and fixed_location into a register.
  - If the latched word count is nonzero go to WRITE; if zero go to ZERO.
- State ZERO: control_done=0 for exactly one cycle, then IDLE.
- State WRITE:
  - control_done=0.
  - master_write = FIFO non-empty.
  - master_address = address register.
  - master_writedata = FIFO head when master_write=1, else 0.
  - On accept (master_write && !master_waitrequest):
    - pop the FIFO;
    - remaining -= 1;
    - address += BYTEENABLEWIDTH unless fixed_location, wrapping modulo 2^ADDRESSWIDTH;
    - if remaining was 1, next state is IDLE.
- Avalon hold rule: while master_waitrequest=1 and master_write=1, address and writedata are held stable. Pushes do not alter the FIFO head, and no pop occurs.
- FIFO empty in WRITE: master_write=0; stay in WRITE until data arrives. There is no timeout.
- control_go outside IDLE is ignored; no queuing.
- Same-cycle go and push in IDLE is legal. The first write is issued the next cycle.
- Latency with waitrequest=0 and data available:
  - go at cycle N → master_write=1 at N+1;
  - for a length of k words → control_done=1 at N+1+k.
- Reset mid-transfer: immediate return to reset values; the in-flight write is abandoned and FIFO contents are discarded.

Test Plan:
- Single word: at cycle N, go with base=0x8000090, length=4, and push 0xDEADBEEF in the same cycle; waitrequest=0 → at N+1 master_write=1, address=0x8000090, writedata=0xDEADBEEF, byteenable=0xF; at N+2 control_done=1 and master_write=0.
- Incrementing burst: pre-push 0x11,0x22,0x33,0x44, then go with base=0x8000000, length=16 → writes to 0x8000000, 0x8000004, 0x8000008, 0x800000C carrying data in push order on 4 consecutive cycles; control_done=0 during the burst and 1 after the fourth write.
- Fixed location: fixed_location=1, base=0x8000068, length=12, three words pushed → all three writes go to 0x8000068; the address register is unchanged at the end.
- Waitrequest stall: one-word transfer with waitrequest=1 for 3 cycles, then 0 → master_write held 4 cycles with address and data constant; exactly one pop; FIFO count returns to 0.
- Full/overflow: in IDLE push 9 words 1..9 → user_buffer_full=1 after the 8th push, word 9 dropped; then go with length=32 → writes data 1..8, then control_done=1.
- Reset and zero length:
  - Drop reset mid-way through a 4-word burst → outputs return to reset values in the same cycle; after release, a new go transfers cleanly.
  - Go with length=0 → control_done=0 for one cycle and no master_write.
